// File: rtl/audio_serialiser.sv
// I2S-style serialiser: a small sample FIFO feeding a 32-bit shift register that is
// clocked out MSB first on sd, with bck divided down from c and lrck marking the channel.
module audio_serialiser #(
    parameter int DIV   = 4,
    parameter int DEPTH = 4
) (
    input  logic        c,
    input  logic        r,
    input  logic [31:0] x,
    input  logic        v,
    output logic        rdy,
    output logic        bck,
    output logic        lrck,
    output logic        sd,
    output logic        urun,
    output logic [4:0]  lvl
);

    localparam int         AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL  = 5'(DEPTH);
    localparam logic [7:0] DCMAX = 8'(DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    state_t        nstate;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [31:0]   shift;
    logic [7:0]    dc;
    logic [4:0]    b;
    logic          wr;
    logic          pop;
    logic          load;
    logic          tick;
    logic          fall;
    logic          wrap;
    logic          empty;

    // rdy is forced high during reset even if the FIFO was full, but writes stay blocked
    assign empty = (lvl == 5'd0);
    assign rdy   = r | (lvl != FULL);
    assign wr    = v & ~r & (lvl != FULL);

    always_ff @(posedge c) begin
        if (r) state <= IDLE;
        else   state <= nstate;
    end

    always_comb begin
        nstate = state;
        pop    = 1'b0;
        load   = 1'b0;
        tick   = 1'b0;
        fall   = 1'b0;
        wrap   = 1'b0;
        urun   = 1'b0;
        sd     = 1'b0;
        lrck   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    load   = 1'b1;
                    nstate = RUN;
                end
            end
            RUN: begin
                sd   = shift[31];
                lrck = b[4];
                tick = (dc == DCMAX);
                fall = tick & bck;
                wrap = fall & (b == 5'd31);
                // frame boundary: reload from the FIFO, or flag an underrun and send silence
                if (wrap) begin
                    if (!empty) pop  = 1'b1;
                    else        urun = 1'b1;
                end
            end
            default: nstate = IDLE;
        endcase
        if (r) begin
            pop  = 1'b0;
            load = 1'b0;
            urun = 1'b0;
        end
    end

    always_ff @(posedge c) begin
        if (wr) mem[wp] <= x;
    end

    always_ff @(posedge c) begin
        if (r) begin
            wp    <= '0;
            rp    <= '0;
            lvl   <= 5'd0;
            shift <= 32'h0;
            dc    <= 8'd0;
            b     <= 5'd0;
            bck   <= 1'b0;
        end else begin
            if (wr)  wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            lvl <= lvl + 5'(wr) - 5'(pop);
            if (state == IDLE) begin
                dc  <= 8'd0;
                b   <= 5'd0;
                bck <= 1'b0;
                if (load) shift <= mem[rp];
            end else begin
                if (tick) begin
                    dc  <= 8'd0;
                    bck <= ~bck;
                end else begin
                    dc <= dc + 8'd1;
                end
                // data and bit index only advance on bck falling edges
                if (fall) begin
                    b <= b + 5'd1;
                    if (wrap) shift <= empty ? 32'h0 : mem[rp];
                    else      shift <= {shift[30:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_serialiser.sv
// Self-checking bench for audio_serialiser: directed table and corner sequences plus
// randomised traffic, all compared every cycle against a queue-based timing model.
module tb_audio_serialiser;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FL    = 64 * DIV;

    logic        c;
    logic        r;
    logic [31:0] x;
    logic        v;
    logic        rdy;
    logic        bck;
    logic        lrck;
    logic        sd;
    logic        urun;
    logic [4:0]  lvl;

    int nChecks = 0;
    int nFails  = 0;
    int urunSeen = 0;

    // behavioural model: accepted words, whether a stream is running, cycles since it started
    logic [31:0] mq[$];
    bit          mrun = 1'b0;
    int          mk   = 0;
    logic [31:0] mcur = 32'h0;

    typedef struct {
        logic        r;
        logic        v;
        logic [31:0] x;
        logic [4:0]  lvl;
        logic        rdy;
        logic        bck;
        logic        sd;
    } vec_t;

    vec_t tbl[9];

    audio_serialiser #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .c(c), .r(r), .x(x), .v(v), .rdy(rdy), .bck(bck),
        .lrck(lrck), .sd(sd), .urun(urun), .lvl(lvl)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: wait bound expired, got timeout expected event at %0t", name, $time);
    endtask

    task automatic applyStimulus(input logic rr, input logic vv, input logic [31:0] xx);
        r = rr;
        v = vv;
        x = xx;
        #1;
    endtask

    task automatic checkOutput();
        int  bi;
        logic expBck, expLrck, expSd, expUrun, expRdy;
        bi      = (mk / (2 * DIV)) % 32;
        expBck  = mrun && (((mk / DIV) % 2) == 1);
        expLrck = mrun && (bi >= 16);
        expSd   = mrun && mcur[31 - bi];
        expUrun = !r && mrun && ((mk % FL) == FL - 1) && (mq.size() == 0);
        expRdy  = r || (mq.size() != DEPTH);
        cmp("model_rdy",  rdy,  expRdy);
        cmp("model_lvl",  lvl,  5'(mq.size()));
        cmp("model_bck",  bck,  expBck);
        cmp("model_lrck", lrck, expLrck);
        cmp("model_sd",   sd,   expSd);
        cmp("model_urun", urun, expUrun);
        if (urun === 1'b1) urunSeen++;
    endtask

    task automatic modelUpdate();
        bit acc;
        if (r) begin
            mq.delete();
            mrun = 1'b0;
            mk   = 0;
            mcur = 32'h0;
        end else begin
            acc = v && (mq.size() < DEPTH);
            if (!mrun) begin
                if (mq.size() != 0) begin
                    mcur = mq.pop_front();
                    mrun = 1'b1;
                    mk   = 0;
                end
            end else begin
                if ((mk % FL) == FL - 1) begin
                    if (mq.size() != 0) mcur = mq.pop_front();
                    else                mcur = 32'h0;
                end
                mk++;
            end
            if (acc) mq.push_back(x);
        end
    endtask

    task automatic stepCycle();
        @(posedge c);
        modelUpdate();
        @(negedge c);
    endtask

    task automatic cycle(input logic rr, input logic vv, input logic [31:0] xx);
        applyStimulus(rr, vv, xx);
        checkOutput();
        stepCycle();
    endtask

    initial begin
        logic [15:0] leftBits;
        logic [15:0] rightBits;
        logic        expBit;
        int          guard;
        int          n;
        bit          acc;

        tbl[0] = '{1'b1, 1'b0, 32'h0,         5'd0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_0011, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 32'h8000_0001, 5'd0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'h8000_0002, 5'd1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 32'h8000_0003, 5'd1, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 32'h8000_0004, 5'd2, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 32'h8000_0005, 5'd3, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 32'h8000_0006, 5'd4, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 32'h0,         5'd4, 1'b0, 1'b1, 1'b1};

        r = 1'b1;
        v = 1'b0;
        x = 32'h0;
        @(negedge c);
        applyStimulus(1'b1, 1'b0, 32'h0);
        stepCycle();
        stepCycle();

        // reset behaviour, fill-to-full and drop of the extra word
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].r, tbl[i].v, tbl[i].x);
            cmp($sformatf("tbl%0d_lvl", i), lvl, tbl[i].lvl);
            cmp($sformatf("tbl%0d_rdy", i), rdy, tbl[i].rdy);
            cmp($sformatf("tbl%0d_bck", i), bck, tbl[i].bck);
            cmp($sformatf("tbl%0d_sd",  i), sd,  tbl[i].sd);
            checkOutput();
            stepCycle();
        end
        // drain the five words, then underrun frames of silence
        for (int i = 0; i < 7 * FL; i++) cycle(1'b0, 1'b0, 32'h0);

        // basic frame of A5A5_0F0F
        leftBits  = 16'b1010010110100101;
        rightBits = 16'b0000111100001111;
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'hA5A5_0F0F);
        cycle(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 2 * DIV; j++) begin
                expBit = (i < 16) ? leftBits[15 - i] : rightBits[31 - i];
                applyStimulus(1'b0, 1'b0, 32'h0);
                cmp("basic_sd",   sd,   expBit);
                cmp("basic_lrck", lrck, (i >= 16));
                cmp("basic_bck",  bck,  (j >= DIV));
                cmp("basic_urun", urun, (i == 31 && j == 2 * DIV - 1));
                checkOutput();
                stepCycle();
            end
        end
        for (int i = 0; i < FL; i++) cycle(1'b0, 1'b0, 32'h0);

        // write and pop colliding at a frame wrap while full
        cycle(1'b1, 1'b0, 32'h0);
        guard = 0;
        while (!(mrun && (mk % FL) == FL - 1) && guard < 4 * FL) begin
            cycle(1'b0, 1'b1, 32'hC0DE_0000 + 32'(guard));
            guard++;
        end
        if (guard >= 4 * FL) timeoutFail("simul_wrap_wait");
        applyStimulus(1'b0, 1'b1, 32'hBEEF_0001);
        cmp("simul_wrap_lvl", lvl, 5'd4);
        cmp("simul_wrap_rdy", rdy, 1'b0);
        checkOutput();
        stepCycle();
        applyStimulus(1'b0, 1'b1, 32'hBEEF_0002);
        cmp("simul_after_lvl", lvl, 5'd3);
        cmp("simul_after_rdy", rdy, 1'b1);
        checkOutput();
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        cmp("simul_accept_lvl", lvl, 5'd4);
        checkOutput();
        stepCycle();
        for (int i = 0; i < 2 * FL; i++) cycle(1'b0, 1'b0, 32'h0);

        // reset in the middle of the second frame
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h1234_5678);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b1, 32'h0F0F_0F0F);
        cycle(1'b0, 1'b1, 32'h5555_AAAA);
        guard = 0;
        while (!(mrun && mk == FL + 20 * DIV + DIV) && guard < 4 * FL) begin
            cycle(1'b0, 1'b0, 32'h0);
            guard++;
        end
        if (guard >= 4 * FL) timeoutFail("midreset_wait");
        applyStimulus(1'b1, 1'b0, 32'h0);
        cmp("midreset_pre_lvl", lvl, 5'd2);
        cmp("midreset_pre_bck", bck, 1'b1);
        checkOutput();
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        cmp("midreset_bck",  bck,  1'b0);
        cmp("midreset_lrck", lrck, 1'b0);
        cmp("midreset_sd",   sd,   1'b0);
        cmp("midreset_lvl",  lvl,  5'd0);
        cmp("midreset_rdy",  rdy,  1'b1);
        checkOutput();
        stepCycle();
        applyStimulus(1'b0, 1'b1, 32'h8000_0001);
        cmp("latency_t0_sd", sd, 1'b0);
        checkOutput();
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        cmp("latency_t1_lvl", lvl, 5'd1);
        cmp("latency_t1_sd",  sd,  1'b0);
        checkOutput();
        stepCycle();
        applyStimulus(1'b0, 1'b0, 32'h0);
        cmp("latency_t2_sd",  sd,  1'b1);
        cmp("latency_t2_lvl", lvl, 5'd0);
        checkOutput();
        stepCycle();

        // twenty sequential words through the wrapping FIFO
        cycle(1'b1, 1'b0, 32'h0);
        urunSeen = 0;
        n = 1;
        guard = 0;
        while (n <= 20 && guard < 30 * FL) begin
            acc = (mq.size() < DEPTH);
            cycle(1'b0, 1'b1, 32'(n));
            if (acc) n++;
            guard++;
        end
        if (guard >= 30 * FL) timeoutFail("wrap_stream_wait");
        guard = 0;
        while (!(mrun && mq.size() == 0 && (mk % FL) == FL - 1) && guard < 10 * FL) begin
            cycle(1'b0, 1'b0, 32'h0);
            guard++;
        end
        if (guard >= 10 * FL) timeoutFail("wrap_drain_wait");
        cmp("wrap_no_urun", urunSeen, 0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        cmp("wrap_end_urun", urun, 1'b1);
        checkOutput();
        stepCycle();

        // randomised traffic at varying densities with rare resets
        cycle(1'b1, 1'b0, 32'h0);
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 1000; i++) begin
                cycle(($urandom_range(0, 1999) == 0), ($urandom_range(0, 5) <= seg), $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/audio_serialiser.md
AUDIO_SERIALISER -- requirements
Module: audio_serialiser

Interface
REQ-001 SHALL have parameter DIV, default 4, giving the number of c cycles per bck half-period (legal 2..255).
REQ-002 SHALL have parameter DEPTH, default 4, giving the sample FIFO depth (power of 2, 2..16).
REQ-003 Port: c  input  1  the block's one clock; all logic SHALL sample on posedge c.
REQ-004 Port: r  input  1  reset; SHALL be synchronous and active-high.
REQ-005 Port: x  input  32  sample word {left[15:0], right[15:0]} from the upstream audio_output stage.
REQ-006 Port: v  input  1  x valid.
REQ-007 Port: rdy  output  1  FIFO can accept a word.
REQ-008 Port: bck  output  1  serial bit clock.
REQ-009 Port: lrck  output  1  channel select; 0 = left, 1 = right.
REQ-010 Port: sd  output  1  serial data, MSB first.
REQ-011 Port: urun  output  1  one-cycle underrun pulse.
REQ-012 Port: lvl  output  5  FIFO occupancy, 0..DEPTH.

Function
REQ-013 A word SHALL be written when v && rdy at posedge c; rdy SHALL equal (lvl != DEPTH), with no bypass when full.
REQ-014 A write and a pop in the same cycle SHALL leave lvl unchanged; a write is allowed only when not full, a pop only when not empty.
REQ-015 The FIFO pointers SHALL wrap modulo DEPTH.
REQ-016 The state machine SHALL have states IDLE and RUN.
REQ-017 In IDLE, outputs SHALL hold bck=0, lrck=0, sd=0.
REQ-018 In IDLE with lvl != 0, the block SHALL pop the head word into a 32-bit shift register and enter RUN next cycle, with divider dc=0 and bit index b=0.
REQ-019 In RUN, dc SHALL count 0..DIV-1; bck SHALL toggle when dc==DIV-1; dc then wraps to 0.
REQ-020 On each bck 1->0 toggle, the shift register SHALL shift left by one and b SHALL increment modulo 32.
REQ-021 sd SHALL equal shift[31] and lrck SHALL equal b[4]; both SHALL change only on bck falling edges.
REQ-022 Frame length SHALL be 64*DIV c cycles (32 bck periods).
REQ-023 On the falling edge where b wraps 31->0, the shift register SHALL load the FIFO head if lvl != 0 (pop in that same cycle); otherwise it SHALL load 32'h0 and urun SHALL be 1 for exactly that cycle.
REQ-024 RUN SHALL never return to IDLE except by reset; underrun frames SHALL transmit zeros with normal bck/lrck timing.
REQ-025 Latency: with the FIFO empty in IDLE, a word written at cycle t SHALL appear with sd=x[31] from cycle t+2 (visible at lvl in t+1, popped at t+1, RUN at t+2).

Reset
REQ-026 While r=1, the block SHALL enter IDLE, flush the FIFO (lvl=0, pointers 0), and clear dc, b, the shift register, bck, lrck, sd and urun.
REQ-027 While r=1, rdy SHALL read 1 and writes SHALL be ignored.
REQ-028 Reset asserted mid-frame SHALL abort the frame; no partial word SHALL be retained.

Verification
REQ-029 Basic: DIV=4; write 32'hA5A5_0F0F into an idle FIFO -> sd serialises 1010010110100101 with lrck=0, then 0000111100001111 with lrck=1; each bit lasts 8 cycles; urun pulses at the next frame wrap.
REQ-030 Full: hold v=1 with no frame wrap for 6 cycles -> lvl rises to 4 (one word popped by IDLE exit, so 5 accepted), rdy=0, and extra words are dropped.
REQ-031 Simultaneous: lvl=4 with v=1 at the frame-wrap cycle -> pop occurs, write is refused that cycle, lvl=3 next cycle, and the write is accepted in the following cycle.
REQ-032 Underrun: stream 3 words then stop -> 3 correct frames, then frames of zeros with one urun pulse per frame, and bck/lrck continue uninterrupted.
REQ-033 Reset mid-frame: assert r at bit 10 of frame 2 with lvl=2 -> next cycle bck=lrck=sd=0, lvl=0, state IDLE; a new word then restarts per REQ-025.
REQ-034 Wrap: stream 20 sequential words (1..20) with DEPTH=4 -> all 20 frames are output in order, with no urun until the stream ends.
